sel_pipe_mux: RTL and testbench
===============================

SEL_PIPE_MUX -- requirements
Module: sel_pipe_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel in bits.
REQ-002 Parameter NUM, default 8, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 3, select width; SHALL equal ceil(log2(NUM)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 mode  input  1  0 = direct select by order; 1 = round-robin arbitration.
REQ-007 order  input  SEL_W  channel index used in direct mode.
REQ-008 in_data  input  NUM*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NUM  per-channel valid.
REQ-010 in_ready  output  NUM  per-channel ready; combinational; at most one bit high.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  registered; out_data holds a word.
REQ-013 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-014 out_sel  output  SEL_W  registered index of the channel that supplied out_data.

Function
REQ-015 Output stage: one register entry; load enable ld = (!out_valid || out_ready).
REQ-016 Grant g: the single channel eligible this cycle; none if no eligible channel.
REQ-017 Direct mode: g = order if order < NUM and in_valid[order]; otherwise no grant.
REQ-018 Direct mode, order >= NUM: no grant, all in_ready = 0, nothing loaded.
REQ-019 RR mode: g = first i with in_valid[i], searched from (ptr+1) mod NUM upward, wrapping NUM-1 -> 0.
REQ-020 RR pointer ptr (SEL_W bits) SHALL update to g only on an input transfer in RR mode; otherwise it holds.
REQ-021 RR pointer SHALL hold unchanged while mode = 0.
REQ-022 in_ready[g] = ld; all other in_ready bits = 0; in_ready SHALL NOT depend on in_valid of channels other than g.
REQ-023 Input transfer occurs when in_valid[g] && in_ready[g]; at that edge out_data <= channel g data, out_sel <= g, out_valid <= 1.
REQ-024 Latency: a word accepted at edge k is visible on out_data at edge k; it is held stable while out_valid && !out_ready.
REQ-025 Output drain without a new transfer (out_ready && out_valid, no grant): out_valid <= 0; out_data and out_sel hold.
REQ-026 Simultaneous drain and transfer in one cycle: new word loaded, out_valid stays 1 (full throughput, one word per cycle).
REQ-027 Stall (out_valid && !out_ready): in_ready all 0; out_data, out_sel, out_valid, ptr all hold.
REQ-028 Mode or order change takes effect in the same cycle for grant; no word already in the output register is altered.
REQ-029 No data is duplicated or dropped: every input transfer produces exactly one output transfer, in acceptance order.

Reset
REQ-030 While rst = 1: out_valid = 0, out_data = 0, out_sel = 0, ptr = NUM-1 (first RR search starts at channel 0), in_ready = 0.
REQ-031 rst asserted mid-transfer SHALL discard the held word immediately; the first edge after rst deasserts may accept new data.

Verification
REQ-032 Direct: mode=0, order=5, in_valid=8'hFF, ch5=32'hA5A5_0005, out_ready=1 -> next edge out_data=32'hA5A5_0005, out_sel=5, out_valid=1; only in_ready[5]=1.
REQ-033 RR fairness: mode=1, in_valid=8'b1000_0101 held, out_ready=1, from reset -> out_sel sequence 0,2,7,0,2,7 on consecutive cycles.
REQ-034 Stall: out_valid=1 holding 32'h1234_5678, out_ready=0 for 3 cycles with new valid inputs -> out_data unchanged, in_ready=0, ptr unchanged; out_ready=1 -> next word loaded same edge.
REQ-035 Out-of-range: NUM=6, mode=0, order=7, all valid -> in_ready=0, out_valid falls to 0 after drain.
REQ-036 Reset mid-operation: out_valid=1, ptr=3, assert rst asynchronously between edges -> out_valid=0, out_data=0 immediately; after release RR grants channel 0 first.
REQ-037 Scoreboard: random valid/ready/mode for 10000 cycles, NUM=8 and NUM=5 -> every accepted word appears once, in order, with correct out_sel.

Source files
------------

// File: rtl/sel_pipe_mux.sv
// Selects one of NUM channels (direct index or round-robin) into a single registered output entry.
// Latency one edge; backpressure: in_ready is offered only while the output entry is empty or draining.
module sel_pipe_mux #(
    parameter int WIDTH = 32,
    parameter int NUM   = 8,
    parameter int SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     order,
    input  logic [NUM*WIDTH-1:0] in_data,
    input  logic [NUM-1:0]       in_valid,
    output logic [NUM-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_sel
);

    localparam int               PAD_W   = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM - 1);

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_sel;

    logic [PAD_W-1:0] w_valid_pad;
    logic [PAD_W-1:0] w_rdy_pad;
    logic             w_ld;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt;
    logic             w_xfer;

    // (p + k) mod NUM, with p < NUM and 1 <= k <= NUM
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM) s = s - NUM;
        return SEL_W'(s);
    endfunction

    // Channels beyond NUM read as never valid, so an out-of-range order yields no grant.
    assign w_valid_pad = PAD_W'(in_valid);

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (!mode) begin
            if (w_valid_pad[order]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = order;
            end
        end else begin
            // Scan farthest-first so the nearest valid channel after r_ptr is the last one written.
            for (int k = NUM; k >= 1; k--) begin
                if (w_valid_pad[rr_idx(r_ptr, k)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = rr_idx(r_ptr, k);
                end
            end
        end
    end

    assign w_ld   = !rst && (!r_out_valid || out_ready);
    assign w_xfer = w_gnt_vld && w_ld;

    always_comb begin
        w_rdy_pad = '0;
        if (w_xfer) w_rdy_pad[w_gnt] = 1'b1;
    end

    assign in_ready = w_rdy_pad[NUM-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= PTR_RST;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_data  <= in_data[int'(w_gnt)*WIDTH +: WIDTH];
            r_out_sel   <= w_gnt;
            r_out_valid <= 1'b1;
            if (mode) r_ptr <= w_gnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Scoreboard bench for sel_pipe_mux: NUM=8 and NUM=5 instances share stimulus, each has its own model.
module tb_sel_pipe_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic [2:0]   order = '0;
    logic [255:0] in_data = '0;
    logic [7:0]   in_valid = '0;
    logic         out_ready = 1'b0;

    logic [7:0]   a_in_ready;
    logic [31:0]  a_out_data;
    logic         a_out_valid;
    logic [2:0]   a_out_sel;
    logic [4:0]   b_in_ready;
    logic [31:0]  b_out_data;
    logic         b_out_valid;
    logic [2:0]   b_out_sel;

    always #5 clk = ~clk;

    sel_pipe_mux #(.WIDTH(32), .NUM(8), .SEL_W(3)) u_a (
        .clk(clk), .rst(rst), .mode(mode), .order(order),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_sel(a_out_sel)
    );

    sel_pipe_mux #(.WIDTH(32), .NUM(5), .SEL_W(3)) u_b (
        .clk(clk), .rst(rst), .mode(mode), .order(order),
        .in_data(in_data[159:0]), .in_valid(in_valid[4:0]), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_sel(b_out_sel)
    );

    typedef struct {
        logic [31:0] dat;
        int          sel;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pa = 7, pb = 4;
    bit   oa = 1'b0, ob = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference grant: the channel the rules select, or -1 for none.
    function automatic int grant(int num, int ptr, logic m, int ord, logic [7:0] v);
        if (!m) return (ord < num && v[ord]) ? ord : -1;
        for (int k = 1; k <= num; k++)
            if (v[(ptr + k) % num]) return (ptr + k) % num;
        return -1;
    endfunction

    // Reference model: predicts in_ready, occupancy and the accepted-word stream.
    always @(negedge clk) begin
        int          ga, gb;
        logic [63:0] er;
        if (rst) begin
            chk("rst_rdy_a", a_in_ready, 0);
            chk("rst_vld_a", a_out_valid, 0);
            chk("rst_rdy_b", b_in_ready, 0);
            chk("rst_vld_b", b_out_valid, 0);
            pa = 7; pb = 4; oa = 1'b0; ob = 1'b0;
            qa.delete(); qb.delete();
        end else begin
            chk("occ_a", a_out_valid, oa);
            chk("occ_b", b_out_valid, ob);

            ga = grant(8, pa, mode, int'(order), in_valid);
            er = '0;
            if (ga >= 0 && (!oa || out_ready)) begin
                er[ga] = 1'b1;
                qa.push_back('{dat: in_data[ga*32 +: 32], sel: ga});
                oa = 1'b1;
                if (mode) pa = ga;
            end else if (out_ready) begin
                oa = 1'b0;
            end
            chk("rdy_a", a_in_ready, er);

            gb = grant(5, pb, mode, int'(order), {3'b000, in_valid[4:0]});
            er = '0;
            if (gb >= 0 && (!ob || out_ready)) begin
                er[gb] = 1'b1;
                qb.push_back('{dat: in_data[gb*32 +: 32], sel: gb});
                ob = 1'b1;
                if (mode) pb = gb;
            end else if (out_ready) begin
                ob = 1'b0;
            end
            chk("rdy_b", b_in_ready, er);
        end
    end

    // Monitor: every output handshake must match the oldest predicted word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop_a: got word %0h expected no word", a_out_data);
                end else begin
                    e = qa.pop_front();
                    chk("dat_a", a_out_data, e.dat);
                    chk("sel_a", a_out_sel, e.sel);
                end
            end
            if (b_out_valid && out_ready) begin
                if (qb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop_b: got word %0h expected no word", b_out_data);
                end else begin
                    e = qb.pop_front();
                    chk("dat_b", b_out_data, e.dat);
                    chk("sel_b", b_out_sel, e.sel);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp[6] = '{0, 2, 7, 0, 2, 7};

        step();
        chk("rst_data", a_out_data, 0);
        chk("rst_sel", a_out_sel, 0);
        step();

        // Direct select of channel 5
        rst = 1'b0;
        mode = 1'b0; order = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) in_data[c*32 +: 32] = 32'hA5A5_0000 | c;
        #1;
        chk("dir_rdy", a_in_ready, 8'h20);
        step();
        chk("dir_data", a_out_data, 32'hA5A5_0005);
        chk("dir_sel", a_out_sel, 5);
        chk("dir_vld", a_out_valid, 1);

        // Round-robin fairness from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode = 1'b1; in_valid = 8'b1000_0101;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_sel", a_out_sel, rr_exp[i]);
        end

        // Stall: held word stays put, pointer does not move
        mode = 1'b0; order = 3'd3; in_valid = 8'hFF;
        in_data[3*32 +: 32] = 32'h1234_5678;
        step();
        chk("stall_load", a_out_data, 32'h1234_5678);
        out_ready = 1'b0; mode = 1'b1;
        in_data[3*32 +: 32] = 32'hDEAD_BEEF;
        in_data[0 +: 32] = 32'hC0C0_C0C0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", a_out_data, 32'h1234_5678);
            chk("stall_rdy", a_in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("unstall_data", a_out_data, 32'hC0C0_C0C0);
        chk("unstall_sel", a_out_sel, 0);

        // Out-of-range order on the NUM=5 instance
        mode = 1'b0; order = 3'd7;
        #1;
        chk("oor7_rdy", b_in_ready, 0);
        step();
        chk("oor7_vld", b_out_valid, 0);
        order = 3'd5;
        #1;
        chk("oor5_rdy", b_in_ready, 0);
        step();
        chk("oor5_vld", b_out_valid, 0);

        // Asynchronous reset with a held word and pointer at 3
        mode = 1'b1; in_valid = 8'h08;
        step();
        chk("pre_rst_sel", a_out_sel, 3);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", a_out_valid, 0);
        chk("arst_data", a_out_data, 0);
        chk("arst_rdy", a_in_ready, 0);
        step();
        rst = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
        step();
        chk("post_rst_sel", a_out_sel, 0);
        chk("post_rst_data", a_out_data, 32'hC0C0_C0C0);

        // Randomized traffic
        for (int n = 0; n < 10000; n++) begin
            step();
            mode  = ($urandom % 4) != 0;
            order = 3'($urandom);
            in_valid = ($urandom % 2) ? 8'($urandom & $urandom) : 8'($urandom);
            out_ready = ($urandom % 4) != 0;
            for (int c = 0; c < 8; c++) in_data[c*32 +: 32] = $urandom;
        end

        step();
        in_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
